// File: rtl/exc_commit.sv
// -----------------------------------------------------------------------------
// exc_commit
//   Consumer side of the exception prioritiser. A single prioritised exception
//   reported at MEM is committed here: the CP0 exception registers are
//   updated, the younger pipeline stages are flushed for FLUSH_CYC cycles,
//   and the exception vector (or the ERET return address) is then offered to
//   fetch over a valid/ready redirect handshake.
//
//   Ports
//     clk, rst        clock, asynchronous active-high reset
//     exc_flag        prioritised exception present this cycle
//     exc_type        exception kind (0 none, 1..13 faults/traps, 14 ERET)
//     exc_baddr       faulting address (AdE/TLBR/TLBI/TLBM)
//     exc_save        1 = store reference (AdES/TLBS codes)
//     exc_pc          PC of the faulting instruction
//     exc_bd          faulting instruction sits in a branch delay slot
//     status_bev      Status.BEV (boot exception vectors)
//     cause_iv        Cause.IV (dedicated interrupt vector)
//     mtc0_we/addr/data  software CP0 write (12 Status.EXL, 14 EPC)
//     flush           kill all younger pipeline stages
//     redir_valid/pc  redirect target offered to fetch
//     redir_ready     fetch accepts the redirect
//     busy            a commit is in progress
//     epc, badvaddr, cause_exccode, cause_bd, status_exl  CP0 state
// -----------------------------------------------------------------------------
module exc_commit #(
  parameter int unsigned FLUSH_CYC = 2,
  parameter logic [31:0] VEC_BEV   = 32'hBFC00200,
  parameter logic [31:0] VEC_NORM  = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_flag,
  input  logic [3:0]  exc_type,
  input  logic [31:0] exc_baddr,
  input  logic        exc_save,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        status_bev,
  input  logic        cause_iv,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready,
  output logic        busy,
  output logic [31:0] epc,
  output logic [31:0] badvaddr,
  output logic [4:0]  cause_exccode,
  output logic        cause_bd,
  output logic        status_exl
);

  localparam logic [3:0] T_NONE = 4'd0;
  localparam logic [3:0] T_INTR = 4'd1;
  localparam logic [3:0] T_ADE  = 4'd2;
  localparam logic [3:0] T_TLBR = 4'd3;
  localparam logic [3:0] T_TLBI = 4'd4;
  localparam logic [3:0] T_TLBM = 4'd5;
  localparam logic [3:0] T_IBE  = 4'd6;
  localparam logic [3:0] T_DBE  = 4'd7;
  localparam logic [3:0] T_CPU  = 4'd8;
  localparam logic [3:0] T_RI   = 4'd9;
  localparam logic [3:0] T_OV   = 4'd10;
  localparam logic [3:0] T_TRAP = 4'd11;
  localparam logic [3:0] T_SYSC = 4'd12;
  localparam logic [3:0] T_BP   = 4'd13;
  localparam logic [3:0] T_ERET = 4'd14;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // The counter is loaded on commit and the FSM leaves FLUSH when it reads 0,
  // so flush-only cycles equal FLUSH_CYC.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_flush;
  logic        w_rvalid;

  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [4:0]  r_exccode;
  logic        r_bd;
  logic        r_exl;
  logic [31:0] r_redir_pc;

  logic        w_valid_type;
  logic        w_commit;
  logic        w_is_eret;
  logic [31:0] w_base;
  logic [31:0] w_target;
  logic [31:0] w_epc_new;

  // ExcCode encoding; address-carrying faults split on load/store.
  function automatic logic [4:0] f_exccode(input logic [3:0] t, input logic st);
    logic [4:0] code;
    case (t)
      T_INTR:         code = 5'd0;
      T_TLBM:         code = 5'd1;
      T_TLBR, T_TLBI: code = st ? 5'd3 : 5'd2;
      T_ADE:          code = st ? 5'd5 : 5'd4;
      T_IBE:          code = 5'd6;
      T_DBE:          code = 5'd7;
      T_SYSC:         code = 5'd8;
      T_BP:           code = 5'd9;
      T_RI:           code = 5'd10;
      T_CPU:          code = 5'd11;
      T_OV:           code = 5'd12;
      T_TRAP:         code = 5'd13;
      default:        code = 5'd0;
    endcase
    return code;
  endfunction

  // Vector offset. TLB refill only uses the fast refill slot when not already
  // at exception level (a nested refill goes through the general vector).
  function automatic logic [31:0] f_vec_offset(input logic [3:0] t,
                                               input logic       exl,
                                               input logic       iv);
    logic [31:0] off;
    if (t == T_TLBR && !exl)
      off = 32'h0000_0000;
    else if (t == T_INTR && iv)
      off = 32'h0000_0200;
    else
      off = 32'h0000_0180;
    return off;
  endfunction

  function automatic logic f_has_baddr(input logic [3:0] t);
    return (t == T_ADE) || (t == T_TLBR) || (t == T_TLBI) || (t == T_TLBM);
  endfunction

  // Code 15 is unassigned and, like 0, is not treated as an exception.
  assign w_valid_type = (exc_type != T_NONE) && (exc_type != 4'd15);
  assign w_commit     = (r_state == S_IDLE) && exc_flag && w_valid_type;
  assign w_is_eret    = (exc_type == T_ERET);
  assign w_base       = status_bev ? VEC_BEV : VEC_NORM;
  assign w_epc_new    = exc_bd ? (exc_pc - 32'd4) : exc_pc;
  // ERET returns to the EPC held before this edge, even if mtc0 rewrites it now.
  assign w_target     = w_is_eret ? r_epc
                                  : (w_base + f_vec_offset(exc_type, r_exl, cause_iv));

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---- next state / outputs ----
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_flush   = 1'b0;
    w_rvalid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_commit) begin
          w_next    = S_FLUSH;
          w_cnt_nxt = CNT_INIT;
        end
      end
      S_FLUSH: begin
        w_flush = 1'b1;
        if (r_cnt == 4'd0)
          w_next = S_REDIR;
        else
          w_cnt_nxt = r_cnt - 4'd1;
      end
      S_REDIR: begin
        w_flush  = 1'b1;
        w_rvalid = 1'b1;
        if (redir_ready)
          w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ---- CP0 exception state and redirect target ----
  // mtc0 writes come first so that a commit in the same cycle overrides every
  // field it touches; fields the commit leaves alone keep the mtc0 value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
      r_exccode  <= 5'd0;
      r_bd       <= 1'b0;
      r_exl      <= 1'b0;
      r_redir_pc <= 32'd0;
    end else begin
      if (mtc0_we && (mtc0_addr == CP0_EPC))
        r_epc <= mtc0_data;
      if (mtc0_we && (mtc0_addr == CP0_STATUS))
        r_exl <= mtc0_data[1];

      if (w_commit) begin
        r_redir_pc <= w_target;
        if (w_is_eret) begin
          r_exl <= 1'b0;
        end else begin
          r_exl     <= 1'b1;
          r_exccode <= f_exccode(exc_type, exc_save);
          // Nested exceptions keep the original return point.
          if (!r_exl) begin
            r_epc <= w_epc_new;
            r_bd  <= exc_bd;
          end
          if (f_has_baddr(exc_type))
            r_badvaddr <= exc_baddr;
        end
      end
    end
  end

  assign flush         = w_flush;
  assign redir_valid   = w_rvalid;
  assign redir_pc      = r_redir_pc;
  assign busy          = (r_state != S_IDLE);
  assign epc           = r_epc;
  assign badvaddr      = r_badvaddr;
  assign cause_exccode = r_exccode;
  assign cause_bd      = r_bd;
  assign status_exl    = r_exl;

endmodule

// File: tb/tb_exc_commit.sv
// -----------------------------------------------------------------------------
// tb_exc_commit
//   Directed scenarios followed by randomized exception traffic for
//   exc_commit. A behavioural reference model tracks the CP0 fields, the
//   redirect target and the commit timeline (idle / flushing / offering).
// -----------------------------------------------------------------------------
module tb_exc_commit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_flag;
  logic [3:0]  exc_type;
  logic [31:0] exc_baddr;
  logic        exc_save;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        status_bev;
  logic        cause_iv;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic        flush;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;
  logic        busy;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [4:0]  cause_exccode;
  logic        cause_bd;
  logic        status_exl;

  exc_commit #(
    .FLUSH_CYC(FC),
    .VEC_BEV  (32'hBFC00200),
    .VEC_NORM (32'h80000000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .exc_flag     (exc_flag),
    .exc_type     (exc_type),
    .exc_baddr    (exc_baddr),
    .exc_save     (exc_save),
    .exc_pc       (exc_pc),
    .exc_bd       (exc_bd),
    .status_bev   (status_bev),
    .cause_iv     (cause_iv),
    .mtc0_we      (mtc0_we),
    .mtc0_addr    (mtc0_addr),
    .mtc0_data    (mtc0_data),
    .flush        (flush),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .redir_ready  (redir_ready),
    .busy         (busy),
    .epc          (epc),
    .badvaddr     (badvaddr),
    .cause_exccode(cause_exccode),
    .cause_bd     (cause_bd),
    .status_exl   (status_exl)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_epc, m_bva, m_rpc;
  logic [4:0]  m_code;
  logic        m_bd, m_exl;
  bit          m_idle;
  int          m_fl;        // flush-only cycles left before the offer
  logic [4:0]  code_tab [16] = '{5'd0, 5'd0, 5'd4, 5'd2, 5'd2, 5'd1, 5'd6, 5'd7,
                                  5'd11, 5'd10, 5'd12, 5'd13, 5'd8, 5'd9, 5'd0, 5'd0};

  int n_chk  = 0;
  int n_fail = 0;
  int n_flush;
  int n_vnr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_epc = 32'd0; m_bva = 32'd0; m_rpc = 32'd0;
    m_code = 5'd0; m_bd = 1'b0; m_exl = 1'b0;
    m_idle = 1'b1; m_fl = 0;
  endtask

  task automatic model_edge();
    logic [31:0] old_epc;
    logic        old_exl;
    logic [31:0] off;
    bit          commit;
    old_epc = m_epc;
    old_exl = m_exl;
    commit  = m_idle && exc_flag && (exc_type != 4'd0) && (exc_type != 4'd15);
    if (!m_idle) begin
      if (m_fl > 0) m_fl--;
      else if (redir_ready) m_idle = 1'b1;
    end
    if (mtc0_we && mtc0_addr == 5'd14) m_epc = mtc0_data;
    if (mtc0_we && mtc0_addr == 5'd12) m_exl = mtc0_data[1];
    if (commit) begin
      m_idle = 1'b0;
      m_fl   = FC;
      if (exc_type == 4'd14) begin
        m_rpc = old_epc;
        m_exl = 1'b0;
      end else begin
        if (!old_exl) begin
          m_epc = exc_pc - (exc_bd ? 32'd4 : 32'd0);
          m_bd  = exc_bd;
        end
        m_exl  = 1'b1;
        m_code = code_tab[exc_type];
        if (exc_save && exc_type inside {4'd2, 4'd3, 4'd4}) m_code = m_code + 5'd1;
        if (exc_type inside {[4'd2:4'd5]}) m_bva = exc_baddr;
        if (exc_type == 4'd3 && !old_exl)      off = 32'h000;
        else if (exc_type == 4'd1 && cause_iv) off = 32'h200;
        else                                   off = 32'h180;
        m_rpc = (status_bev ? 32'hBFC00200 : 32'h80000000) + off;
      end
    end
  endtask

  task automatic check_all();
    chk("flush",       32'(flush),         32'(!m_idle));
    chk("redir_valid", 32'(redir_valid),   32'(!m_idle && m_fl == 0));
    chk("busy",        32'(busy),          32'(!m_idle));
    chk("redir_pc",    redir_pc,           m_rpc);
    chk("epc",         epc,                m_epc);
    chk("badvaddr",    badvaddr,           m_bva);
    chk("exccode",     32'(cause_exccode), 32'(m_code));
    chk("cause_bd",    32'(cause_bd),      32'(m_bd));
    chk("status_exl",  32'(status_exl),    32'(m_exl));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (flush) n_flush++;
    if (redir_valid && !redir_ready) n_vnr++;
    @(negedge clk);
    exc_flag = 1'b0;
    mtc0_we  = 1'b0;
  endtask

  task automatic noise(input bit busy_phase);
    mtc0_we   = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 2))
      0:       mtc0_addr = 5'd12;
      1:       mtc0_addr = 5'd14;
      default: mtc0_addr = 5'($urandom);
    endcase
    mtc0_data = $urandom;
    exc_flag  = $urandom_range(0, 1);
    exc_type  = busy_phase ? 4'($urandom_range(1, 14)) : 4'd0;
    exc_pc    = $urandom;
    exc_baddr = $urandom;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; mtc0_addr = a; mtc0_data = d;
    tick();
  endtask

  task automatic exc(input logic [3:0] t, input logic [31:0] pc, input logic [31:0] ba,
                     input logic sv, input logic bd, input logic bev, input logic iv);
    exc_flag = 1'b1; exc_type = t; exc_pc = pc; exc_baddr = ba;
    exc_save = sv; exc_bd = bd; status_bev = bev; cause_iv = iv;
    tick();
  endtask

  // Run the commit to completion; the redirect is refused for 'hold' offered cycles.
  task automatic drain(input int hold, input bit noisy);
    int held;
    held = 0;
    redir_ready = 1'b0;
    for (int n = 0; n < 200 && !m_idle; n++) begin
      if (m_fl == 0 && held >= hold) redir_ready = 1'b1;
      if (noisy) noise(1'b1);
      tick();
      if (!m_idle && m_fl == 0) held++;
    end
    chk("drain_timeout", 32'(m_idle), 32'd1);
    redir_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    exc_flag = 1'b0; exc_type = 4'd0; exc_baddr = 32'd0; exc_save = 1'b0;
    exc_pc = 32'd0; exc_bd = 1'b0; status_bev = 1'b0; cause_iv = 1'b0;
    mtc0_we = 1'b0; mtc0_addr = 5'd0; mtc0_data = 32'd0; redir_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: SysC from a normal slot
    n_flush = 0;
    exc(4'd12, 32'h80001000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_epc", epc, 32'h80001000);
    chk("t1_code", 32'(cause_exccode), 32'd8);
    chk("t1_exl", 32'(status_exl), 32'd1);
    drain(0, 1'b0);
    chk("t1_flush_cycles", 32'(n_flush), 32'd3);
    chk("t1_redir_pc", redir_pc, 32'h80000180);

    // 2: TLBI store from a delay slot
    mtc0(5'd12, 32'd0);
    exc(4'd4, 32'h80002004, 32'h00400000, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_epc", epc, 32'h80002000);
    chk("t2_bd", 32'(cause_bd), 32'd1);
    chk("t2_code", 32'(cause_exccode), 32'd3);
    chk("t2_badvaddr", badvaddr, 32'h00400000);
    drain(1, 1'b0);

    // 3: TLBR with BEV, first at exl=0 then nested at exl=1
    mtc0(5'd12, 32'd0);
    exc(4'd3, 32'h80004000, 32'h00001000, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(0, 1'b0);
    chk("t3_redir_refill", redir_pc, 32'hBFC00200);
    exc(4'd3, 32'h80005000, 32'h00002000, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(0, 1'b0);
    chk("t3_redir_nested", redir_pc, 32'hBFC00380);
    chk("t3_epc_kept", epc, 32'h80004000);

    // 4: ERET with redirect refused for 4 cycles
    mtc0(5'd14, 32'h80003000);
    mtc0(5'd12, 32'd2);
    n_vnr = 0;
    exc(4'd14, 32'h80009990, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_exl", 32'(status_exl), 32'd0);
    chk("t4_redir_pc", redir_pc, 32'h80003000);
    drain(4, 1'b0);
    chk("t4_valid_held", 32'(n_vnr), 32'd4);

    // 5: interrupt on the IV vector with a colliding mtc0 EPC write
    mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_data = 32'h00001234;
    exc(4'd1, 32'h80006000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_epc", epc, 32'h80006000);
    drain(0, 1'b0);
    chk("t5_redir_pc", redir_pc, 32'h80000200);

    // 6: asynchronous reset while offering the redirect
    exc(4'd10, 32'h80007000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    redir_ready = 1'b0;
    for (int n = 0; n < 20 && m_fl != 0; n++) tick();
    chk("t6_in_redir", 32'(redir_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_flush", 32'(flush), 32'd0);
    chk("t6_valid", 32'(redir_valid), 32'd0);
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int idle_n;
      idle_n = $urandom_range(0, 2);
      for (int k = 0; k < idle_n; k++) begin
        noise(1'b0);
        tick();
      end
      if ($urandom_range(0, 1) == 1) begin
        mtc0_we   = 1'b1;
        mtc0_addr = ($urandom_range(0, 1) == 1) ? 5'd12 : 5'd14;
        mtc0_data = $urandom;
      end
      exc(4'($urandom_range(1, 14)), $urandom, $urandom, 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom));
      drain($urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
